// File: rtl/sc_sar_search_controller.sv
// Successive-approximation search controller around a 3-flag magnitude comparator.
// Latency: k SEARCH cycles (1..W) after the start edge, then a one-cycle done pulse.
// Backpressure: none; start is sampled only in IDLE/ERROR, ignored while busy or in DONE.
//
// Ports:
//   SC_SARSEARCH_CLOCK_50          clock, rising edge
//   SC_SARSEARCH_RESET_InLow       asynchronous active-low reset
//   SC_SARSEARCH_start_In          request a new search
//   SC_SARSEARCH_greaterthan_In    comparator flag dataA > trial
//   SC_SARSEARCH_lessthan_In       comparator flag dataA < trial
//   SC_SARSEARCH_equal_In          comparator flag dataA == trial
//   SC_SARSEARCH_trial_OutBUS      registered trial value (comparator dataB)
//   SC_SARSEARCH_result_OutBUS     recovered value, held until next completed search
//   SC_SARSEARCH_busy_Out          high while searching
//   SC_SARSEARCH_done_Out          one-cycle pulse when result updates
//   SC_SARSEARCH_exact_Out         result ended on an equal flag
//   SC_SARSEARCH_error_Out         sticky inconsistent-flag indication
module sc_sar_search_controller #(
    parameter int NUMBER_DATAWIDTH = 8
) (
    input  logic                        SC_SARSEARCH_CLOCK_50,
    input  logic                        SC_SARSEARCH_RESET_InLow,
    input  logic                        SC_SARSEARCH_start_In,
    input  logic                        SC_SARSEARCH_greaterthan_In,
    input  logic                        SC_SARSEARCH_lessthan_In,
    input  logic                        SC_SARSEARCH_equal_In,
    output logic [NUMBER_DATAWIDTH-1:0] SC_SARSEARCH_trial_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] SC_SARSEARCH_result_OutBUS,
    output logic                        SC_SARSEARCH_busy_Out,
    output logic                        SC_SARSEARCH_done_Out,
    output logic                        SC_SARSEARCH_exact_Out,
    output logic                        SC_SARSEARCH_error_Out
);

    localparam int W  = NUMBER_DATAWIDTH;
    localparam int IW = (W > 2) ? $clog2(W) : 1;

    localparam logic [W-1:0]  MSB_ONLY = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  ONE      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0] TOP_IDX  = IW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   bit_idx;

    logic [W-1:0]    cur_mask;
    logic [W-1:0]    adj_trial;
    logic            flags_ok;

    // Exactly one comparator flag must be asserted for the trial to be meaningful.
    always_comb begin
        cur_mask  = ONE << bit_idx;
        flags_ok  = ({SC_SARSEARCH_greaterthan_In, SC_SARSEARCH_lessthan_In,
                      SC_SARSEARCH_equal_In} == 3'b100) ||
                    ({SC_SARSEARCH_greaterthan_In, SC_SARSEARCH_lessthan_In,
                      SC_SARSEARCH_equal_In} == 3'b010) ||
                    ({SC_SARSEARCH_greaterthan_In, SC_SARSEARCH_lessthan_In,
                      SC_SARSEARCH_equal_In} == 3'b001);
        // Greater keeps the trial bit; less clears it. Lower bits are still zero,
        // so no carries can occur.
        adj_trial = SC_SARSEARCH_greaterthan_In ? SC_SARSEARCH_trial_OutBUS
                                                : (SC_SARSEARCH_trial_OutBUS & ~cur_mask);
    end

    always_ff @(posedge SC_SARSEARCH_CLOCK_50 or negedge SC_SARSEARCH_RESET_InLow) begin
        if (!SC_SARSEARCH_RESET_InLow) begin
            state                      <= S_IDLE;
            bit_idx                    <= TOP_IDX;
            SC_SARSEARCH_trial_OutBUS  <= '0;
            SC_SARSEARCH_result_OutBUS <= '0;
            SC_SARSEARCH_busy_Out      <= 1'b0;
            SC_SARSEARCH_done_Out      <= 1'b0;
            SC_SARSEARCH_exact_Out     <= 1'b0;
            SC_SARSEARCH_error_Out     <= 1'b0;
        end else begin
            SC_SARSEARCH_done_Out <= 1'b0;
            case (state)
                // ERROR recovers exactly like an IDLE start.
                S_IDLE, S_ERROR: begin
                    if (SC_SARSEARCH_start_In) begin
                        SC_SARSEARCH_trial_OutBUS <= MSB_ONLY;
                        bit_idx                   <= TOP_IDX;
                        SC_SARSEARCH_error_Out    <= 1'b0;
                        SC_SARSEARCH_busy_Out     <= 1'b1;
                        state                     <= S_SEARCH;
                    end
                end

                S_SEARCH: begin
                    if (!flags_ok) begin
                        SC_SARSEARCH_error_Out <= 1'b1;
                        SC_SARSEARCH_busy_Out  <= 1'b0;
                        state                  <= S_ERROR;
                    end else if (SC_SARSEARCH_equal_In) begin
                        SC_SARSEARCH_result_OutBUS <= SC_SARSEARCH_trial_OutBUS;
                        SC_SARSEARCH_exact_Out     <= 1'b1;
                        SC_SARSEARCH_done_Out      <= 1'b1;
                        SC_SARSEARCH_busy_Out      <= 1'b0;
                        state                      <= S_DONE;
                    end else if (bit_idx == '0) begin
                        SC_SARSEARCH_result_OutBUS <= adj_trial;
                        SC_SARSEARCH_exact_Out     <= 1'b0;
                        SC_SARSEARCH_done_Out      <= 1'b1;
                        SC_SARSEARCH_busy_Out      <= 1'b0;
                        state                      <= S_DONE;
                    end else begin
                        SC_SARSEARCH_trial_OutBUS <= adj_trial | (cur_mask >> 1);
                        bit_idx                   <= bit_idx - IW'(1);
                    end
                end

                // done is high during this cycle only; any start here is dropped.
                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_sar_search_controller.sv
module tb_sc_sar_search_controller;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         gt, lt, eq;
    logic [W-1:0] trial, result;
    logic         busy, done, exact, error;

    logic [W-1:0] data_a;
    logic         inj;

    int checks;
    int failures;

    // Observations from one search run
    logic [W-1:0] obs_trials[$];
    int           obs_done_cyc;
    int           obs_done_cnt;
    int           obs_busy_cnt;

    // Reference model outputs
    logic [W-1:0] exp_trials[$];
    logic [W-1:0] exp_result;
    logic         exp_exact;

    sc_sar_search_controller #(.NUMBER_DATAWIDTH(W)) dut (
        .SC_SARSEARCH_CLOCK_50       (clk),
        .SC_SARSEARCH_RESET_InLow    (rst_n),
        .SC_SARSEARCH_start_In       (start),
        .SC_SARSEARCH_greaterthan_In (gt),
        .SC_SARSEARCH_lessthan_In    (lt),
        .SC_SARSEARCH_equal_In       (eq),
        .SC_SARSEARCH_trial_OutBUS   (trial),
        .SC_SARSEARCH_result_OutBUS  (result),
        .SC_SARSEARCH_busy_Out       (busy),
        .SC_SARSEARCH_done_Out       (done),
        .SC_SARSEARCH_exact_Out      (exact),
        .SC_SARSEARCH_error_Out      (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural comparator; inj forces an illegal gt+lt combination.
    always_comb begin
        gt = (data_a > trial) | inj;
        lt = (data_a < trial) | inj;
        eq = (data_a == trial);
    end

    // Binary search over the value range: each trial is the midpoint of the
    // remaining interval [lo, lo + span).
    function automatic void compute_model(input logic [W-1:0] a);
        int lo;
        int span;
        int t;
        exp_trials.delete();
        lo   = 0;
        span = 1 << W;
        while (span > 1) begin
            span = span / 2;
            t    = lo + span;
            exp_trials.push_back(W'(t));
            if (t == int'(a)) begin
                exp_result = W'(t);
                exp_exact  = 1'b1;
                return;
            end
            if (int'(a) > t) lo = t;
        end
        exp_result = W'(lo);
        exp_exact  = 1'b0;
    endfunction

    // Start a search and observe 14 cycles. poke_at / inj_at select the cycle
    // (1 = first cycle after the start edge) where start / bad flags are driven.
    task automatic run_search(input logic [W-1:0] a, input int poke_at, input int inj_at);
        data_a = a;
        obs_trials.delete();
        obs_done_cyc = -1;
        obs_done_cnt = 0;
        obs_busy_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (busy) begin
                obs_trials.push_back(trial);
                obs_busy_cnt++;
            end
            if (done) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) obs_done_cyc = c;
            end
            start = (c == poke_at);
            inj   = (c == inj_at);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        inj   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; inj = 1'b0; data_a = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({trial, result, busy, done, exact, error} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {trial, result, busy, done, exact, error});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({trial, busy, done, error} !== '0) begin
            failures++;
            $display("FAIL idle_after_release got=%h exp=0", {trial, busy, done, error});
        end
    endtask

    task automatic test_clean_search(input string tag, input logic [W-1:0] a, input int poke_at);
        compute_model(a);
        run_search(a, poke_at, 0);
        checks++;
        if (obs_trials.size() != exp_trials.size()) begin
            failures++;
            $display("FAIL %s trial_count got=%0d exp=%0d", tag, obs_trials.size(), exp_trials.size());
        end else begin
            for (int i = 0; i < exp_trials.size(); i++) begin
                checks++;
                if (obs_trials[i] !== exp_trials[i]) begin
                    failures++;
                    $display("FAIL %s trial[%0d] got=%h exp=%h", tag, i, obs_trials[i], exp_trials[i]);
                end
            end
        end
        checks++;
        if (obs_done_cyc != exp_trials.size() + 1) begin
            failures++;
            $display("FAIL %s done_cycle got=%0d exp=%0d", tag, obs_done_cyc, exp_trials.size() + 1);
        end
        checks++;
        if (obs_done_cnt != 1) begin
            failures++;
            $display("FAIL %s done_pulses got=%0d exp=1", tag, obs_done_cnt);
        end
        checks++;
        if (obs_busy_cnt != exp_trials.size()) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d exp=%0d", tag, obs_busy_cnt, exp_trials.size());
        end
        checks++;
        if (result !== a || result !== exp_result) begin
            failures++;
            $display("FAIL %s result got=%h exp=%h", tag, result, exp_result);
        end
        checks++;
        if (exact !== exp_exact || error !== 1'b0) begin
            failures++;
            $display("FAIL %s exact_error got=%b%b exp=%b0", tag, exact, error, exp_exact);
        end
        checks++;
        if (trial !== exp_trials[exp_trials.size() - 1]) begin
            failures++;
            $display("FAIL %s trial_hold got=%h exp=%h", tag, trial, exp_trials[exp_trials.size() - 1]);
        end
    endtask

    task automatic test_known_vectors();
        logic [W-1:0] seq5a[7];
        seq5a = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A};
        test_clean_search("msb_equal", 8'h80, 0);
        test_clean_search("msb_start_in_done", 8'h80, 2);
        test_clean_search("all_zero", 8'h00, 0);
        test_clean_search("all_ones", 8'hFF, 0);
        test_clean_search("val_5a_restart", 8'h5A, 3);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (i >= obs_trials.size() || obs_trials[i] !== seq5a[i]) begin
                failures++;
                $display("FAIL seq5a[%0d] got=%h exp=%h", i,
                         (i < obs_trials.size()) ? obs_trials[i] : 8'hxx, seq5a[i]);
            end
        end
    endtask

    task automatic test_error();
        logic [W-1:0] prior_result;
        logic         prior_exact;
        logic [W-1:0] a;
        prior_result = result;
        prior_exact  = exact;
        a = W'($urandom) | 8'h01;
        run_search(a, 0, 2);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL error_state got=err%b busy%b exp=err1 busy0", error, busy);
        end
        checks++;
        if (obs_done_cnt != 0) begin
            failures++;
            $display("FAIL error_no_done got=%0d exp=0", obs_done_cnt);
        end
        checks++;
        if (obs_busy_cnt != 2) begin
            failures++;
            $display("FAIL error_busy_cycles got=%0d exp=2", obs_busy_cnt);
        end
        checks++;
        if (result !== prior_result || exact !== prior_exact) begin
            failures++;
            $display("FAIL error_result_held got=%h/%b exp=%h/%b", result, exact, prior_result, prior_exact);
        end
        test_clean_search("after_error", W'($urandom), 0);
    endtask

    task automatic test_reset_mid();
        data_a = W'($urandom) | 8'h01;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_precond busy got=%b exp=1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({trial, result, busy, done, exact, error} !== '0) begin
            failures++;
            $display("FAIL reset_mid_async got=%h exp=0", {trial, result, busy, done, exact, error});
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_no_done got=%b exp=0", done);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_clean_search("after_reset_33", 8'h33, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            test_clean_search("random", W'($urandom), 0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_known_vectors();
        test_error();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sc_sar_search_controller.md
Name: sc_sar_search_controller

Overview:
- Sequential successive-approximation controller that sits on both sides of the team's 3-flag magnitude comparator.
- Drives the comparator's dataB bus with a registered trial value.
- Consumes the comparator's greater-than / less-than / equal flags, where dataA is an unknown operand.
- Binary-searches dataA in at most NUMBER_DATAWIDTH cycles and reports the recovered value with a done pulse.

Parameters:
NUMBER_DATAWIDTH, 8, width of the trial/result buses; must match the comparator width (≥2).

Ports:
SC_SARSEARCH_CLOCK_50  input  1  system clock, all state updates on the rising edge
SC_SARSEARCH_RESET_InLow  input  1  asynchronous active-low reset
SC_SARSEARCH_start_In  input  1  request a new search; sampled only in IDLE
SC_SARSEARCH_greaterthan_In  input  1  comparator flag: dataA > trial
SC_SARSEARCH_lessthan_In  input  1  comparator flag: dataA < trial
SC_SARSEARCH_equal_In  input  1  comparator flag: dataA == trial
SC_SARSEARCH_trial_OutBUS  output  NUMBER_DATAWIDTH  registered trial value, feeds comparator dataB
SC_SARSEARCH_result_OutBUS  output  NUMBER_DATAWIDTH  recovered value, held until the next completed search
SC_SARSEARCH_busy_Out  output  1  high in SEARCH
SC_SARSEARCH_done_Out  output  1  one-cycle pulse when result is updated
SC_SARSEARCH_exact_Out  output  1  result ended on an equal flag (held with result)
SC_SARSEARCH_error_Out  output  1  sticky: inconsistent comparator flags seen

Behaviour:
- Reset (async, RESET_InLow=0):
  - State=IDLE; trial=0, result=0, busy=0, done=0, exact=0, error=0; bit index=NUMBER_DATAWIDTH-1.
  - Reset release is synchronous to the next edge. Reset asserted mid-search aborts immediately, with no done pulse.
- States: IDLE, SEARCH, DONE, ERROR.
- IDLE:
  - start=1 → trial = 1<<(W-1), bit index=W-1, error cleared, → SEARCH.
  - start=0 → trial holds its last value.
- SEARCH: one evaluation per clock. Flags are assumed combinational from the registered trial, so they are sampled on the same edge. Flag consistency is checked every SEARCH cycle: exactly one flag must be high.
  - Zero or more than one flag high → error=1, → ERROR; result, exact and done unchanged.
  - equal=1 → result=trial, exact=1, → DONE (early termination).
  - greaterthan=1 → keep the current bit.
  - lessthan=1 → clear the current bit.
  - bit index=0 → result = adjusted trial, exact=0, → DONE.
  - Otherwise → trial = adjusted trial | 1<<(index-1), index decremented.
- DONE: done=1 for exactly this cycle; busy=0; → IDLE next cycle. A start seen in DONE is ignored.
- ERROR:
  - Stays until start=1, which behaves as the IDLE start (new search, error cleared).
  - error stays high while in ERROR.
- busy = (state==SEARCH), registered.
- start while busy is ignored; there is no queueing.
- Latency: from the start edge to the done pulse is k+1 cycles, where k is the number of SEARCH cycles, 1 ≤ k ≤ W.
- Arithmetic: all bit operations are unsigned, width W, and there are no carries.
- The integer search always converges. For any dataA in [0, 2^W-1], result==dataA.
- dataA must be stable during SEARCH. A change mid-search is not detected; result is whatever the search converges to, with no error.

Test Plan:
- W=8, model comparator with dataA=8'h80; start → first SEARCH cycle equal → result=8'h80, exact=1, done 2 cycles after start.
- dataA=8'h00 → trials 80,40,20,10,08,04,02,01 all lessthan → result=8'h00, exact=0, busy 8 cycles, done at cycle 9.
- dataA=8'hFF → trials 80,C0,E0,F0,F8,FC,FE,FF; equal on the 8th → result=8'hFF, exact=1.
- dataA=8'h5A → trial sequence 80,40,60,50,58,5C,5A then equal → result=8'h5A, exact=1. Assert start again while busy → no restart, sequence unchanged.
- Force greaterthan=lessthan=1 on the 2nd SEARCH cycle → error=1, state ERROR, no done, result keeps its prior value. Next start → error=0 and a clean search completes.
- Assert RESET_InLow=0 on the 4th SEARCH cycle → all outputs 0 asynchronously, no done pulse. After release, a start searches dataA=8'h33 to result=8'h33.
